seq_divider: RTL and testbench

- Iterative signed 32/32 divider that produces the quotient/remainder pair for the ALU's divide/mod operation.
- Sits directly upstream of the ALU result registers: Z[31:0] (quotient) feeds the LO half and Z[63:32] (remainder) feeds the HI half.
- Radix-2 restoring algorithm on operand magnitudes, with a final sign-fixup cycle.
- Start/busy/done handshake, so the control sequencer stalls until the result is valid.

---
 rtl/seq_divider.sv | 83 ++++++++
 tb/tb_seq_divider.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring signed divider, Z = {remainder, quotient}.
// Define DIV_UNSIGNED_EN to add the is_unsigned port for unsigned divisions.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
`ifdef DIV_UNSIGNED_EN
  input  logic               is_unsigned,
`endif
  output logic [2*WIDTH-1:0] Z,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;
  logic [WIDTH-1:0] rem, quo, dvs, mag_a, mag_b, q_fix, r_fix;
  logic [WIDTH:0] rem_sh, trial;
  logic [CW-1:0] cnt;
  logic sign_q, sign_r, uns;
`ifdef DIV_UNSIGNED_EN
  assign uns = is_unsigned;
`else
  assign uns = 1'b0;
`endif
  // a zero divisor leaves |A| in quo, so re-applying the dividend sign restores A
  always_comb begin
    mag_a = (!uns && A[WIDTH-1]) ? -A : A;
    mag_b = (!uns && B[WIDTH-1]) ? -B : B;
    rem_sh = {rem, quo[WIDTH-1]};
    trial = rem_sh - {1'b0, dvs};
    q_fix = (dvs == '0) ? '1 : sign_q ? -quo : quo;
    r_fix = (dvs == '0) ? (sign_r ? -quo : quo) : sign_r ? -rem : rem;
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= IDLE;
      Z <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sign_q <= !uns && (A[WIDTH-1] ^ B[WIDTH-1]);
          sign_r <= !uns && A[WIDTH-1];
          quo <= mag_a;
          dvs <= mag_b;
          rem <= '0;
          cnt <= '0;
          busy <= 1'b1;
          state <= (B == '0) ? FIX : CALC;
        end
        CALC: begin
          rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          Z <= {r_fix, q_fix};
          div_by_zero <= (dvs == '0);
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven and scoreboard checks of seq_divider (signed default build).
module tb_seq_divider;
  logic clk = 1'b0, clr_n = 1'b0, start = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [63:0] Z;
  logic busy, done, div_by_zero;
  int checks = 0, errors = 0;
  logic [63:0] last_z = '0;

  typedef struct {logic [31:0] a, b; logic [63:0] z; logic dz; bit mid;} vec_t;
  typedef struct {logic [63:0] z; logic dz;} exp_t;
  exp_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk),
    .clr_n(clr_n),
    .start(start),
    .A(A),
    .B(B),
`ifdef DIV_UNSIGNED_EN
    .is_unsigned(1'b0),
`endif
    .Z(Z),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s got done with empty scoreboard expected pending result", name);
    end else begin
      checks--;
      e = sb.pop_front();
      chk({name, "_z"}, Z, e.z);
      chk({name, "_dz"}, {63'd0, div_by_zero}, {63'd0, e.dz});
      last_z = e.z;
    end
  endtask

  task automatic run_div(input vec_t v, input string name);
    int n, lat;
    lat = (v.b == 0) ? 1 : 33;
    @(negedge clk);
    A = v.a; B = v.b; start = 1'b1;
    sb.push_back('{v.z, v.dz});
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1 && lat > 1) chk({name, "_busy"}, {63'd0, busy}, 64'd1);
      if (n == 5 && v.mid) begin start = 1'b1; A = 32'd1; B = 32'd1; end
      if (n == 6) start = 1'b0;
      if (n == 16 && lat > 1) chk({name, "_zhold"}, Z, last_z);
    end while (!done && n < 100);
    chk({name, "_lat"}, 64'(n), 64'(lat));
    if (done) pop_check(name);
    @(posedge clk); #1;
    chk({name, "_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int n, t1, t2;
    logic signed [31:0] sa, sbv;
    vecs.push_back('{32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 1'b0});
    vecs.push_back('{-32'sd100, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b0, 1'b1});
    vecs.push_back('{32'd100, -32'sd7, 64'h00000002_FFFFFFF2, 1'b0, 1'b0});
    vecs.push_back('{-32'sd100, -32'sd7, 64'hFFFFFFFE_0000000E, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 1'b0});
    vecs.push_back('{32'd7, 32'd100, 64'h00000007_00000000, 1'b0, 1'b1});
    vecs.push_back('{32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'd9, 32'd3, 64'h00000000_00000003, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 32'd0, 64'h80000000_FFFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'h80000000, 64'hFFFFFFFF_00000000, 1'b0, 1'b0});
    vecs.push_back('{32'h7FFFFFFF, 32'd1, 64'h00000000_7FFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 32'd2, 64'h00000000_C0000000, 1'b0, 1'b0});
    vecs.push_back('{-32'sd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b0});
    for (int i = 0; i < 6; i++) begin
      sa = $urandom;
      sbv = $urandom >> $urandom_range(0, 28);
      if (sbv == 0) sbv = 1;
      vecs.push_back('{sa, sbv, {32'(sa % sbv), 32'(sa / sbv)}, 1'b0, 1'b0});
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_z", Z, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk) clr_n = 1'b1;

    foreach (vecs[i]) run_div(vecs[i], $sformatf("vec%0d", i));

    // reset mid-division with a stray start pulse during CALC
    @(negedge clk);
    A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 start = 1'b1; A = 32'd1; B = 32'd1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", {63'd0, busy}, 64'd1);
    @(negedge clk) clr_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_z", Z, 64'd0);
    @(negedge clk) clr_n = 1'b1;
    last_z = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_idle", {63'd0, busy}, 64'd0);
    run_div('{32'd50, 32'd5, 64'h00000000_0000000A, 1'b0, 1'b0}, "after_rst");

    // start held high: second operands accepted in the first done cycle
    @(negedge clk);
    A = 32'd100; B = 32'd7; start = 1'b1;
    sb.push_back('{64'h00000002_0000000E, 1'b0});
    sb.push_back('{64'h00000002_00000006, 1'b0});
    @(posedge clk); #1;
    A = 32'd20; B = 32'd3;
    n = 0; t1 = 0; t2 = 0;
    while (t2 == 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        if (t1 == 0) t1 = n; else t2 = n;
        pop_check("b2b");
      end else if (t1 != 0 && n == t1 + 1) begin
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        start = 1'b0;
      end
    end
    chk("b2b_first", 64'(t1), 64'd33);
    chk("b2b_gap", 64'(t2 - t1), 64'd34);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
